// File: rtl/id_ex_pipe_reg.sv
// id_ex_pipe_reg: MIPS ID/EX pipeline register with stall, flush, valid tracking and load-use detection.
// Define ID_EX_STALL_CNT_EN to enable the saturating stall-cycle counter on stall_cnt.
module id_ex_pipe_reg #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall,
    input  logic                  flush,
    input  logic                  id_valid,
    input  logic [DATA_W-1:0]     id_pc_plus4,
    input  logic [DATA_W-1:0]     id_rd_data1,
    input  logic [DATA_W-1:0]     id_rd_data2,
    input  logic [DATA_W-1:0]     id_imm_ext,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  id_reg_write,
    input  logic                  id_mem_to_reg,
    input  logic                  id_mem_read,
    input  logic                  id_mem_write,
    input  logic                  id_branch,
    input  logic                  id_alu_src,
    input  logic                  id_reg_dst,
    input  logic [1:0]            id_alu_op,
    output logic                  ex_valid,
    output logic [DATA_W-1:0]     ex_pc_plus4,
    output logic [DATA_W-1:0]     ex_rd_data1,
    output logic [DATA_W-1:0]     ex_rd_data2,
    output logic [DATA_W-1:0]     ex_imm_ext,
    output logic [REG_ADDR_W-1:0] ex_rs,
    output logic [REG_ADDR_W-1:0] ex_rt,
    output logic [REG_ADDR_W-1:0] ex_rd,
    output logic                  ex_reg_write,
    output logic                  ex_mem_to_reg,
    output logic                  ex_mem_read,
    output logic                  ex_mem_write,
    output logic                  ex_branch,
    output logic                  ex_alu_src,
    output logic                  ex_reg_dst,
    output logic [1:0]            ex_alu_op,
    output logic                  load_use,
    output logic [15:0]           stall_cnt
);
    typedef struct packed {
        logic                  valid;
        logic [DATA_W-1:0]     pc_plus4;
        logic [DATA_W-1:0]     rd_data1;
        logic [DATA_W-1:0]     rd_data2;
        logic [DATA_W-1:0]     imm_ext;
        logic [REG_ADDR_W-1:0] rs;
        logic [REG_ADDR_W-1:0] rt;
        logic [REG_ADDR_W-1:0] rd;
        logic                  reg_write;
        logic                  mem_to_reg;
        logic                  mem_read;
        logic                  mem_write;
        logic                  branch;
        logic                  alu_src;
        logic                  reg_dst;
        logic [1:0]            alu_op;
    } stage_t;

    stage_t stage_q, stage_d, load;

    always_comb begin
        load            = '0;
        load.valid      = id_valid;
        load.pc_plus4   = id_pc_plus4;
        load.rd_data1   = id_rd_data1;
        load.rd_data2   = id_rd_data2;
        load.imm_ext    = id_imm_ext;
        load.rs         = id_rs;
        load.rt         = id_rt;
        load.rd         = id_rd;
        // An invalid slot must never commit architectural state.
        load.reg_write  = id_reg_write & id_valid;
        load.mem_to_reg = id_mem_to_reg;
        load.mem_read   = id_mem_read;
        load.mem_write  = id_mem_write & id_valid;
        load.branch     = id_branch;
        load.alu_src    = id_alu_src;
        load.reg_dst    = id_reg_dst;
        load.alu_op     = id_alu_op;
        stage_d         = flush ? '0 : (stall ? stage_q : load);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) stage_q <= '0;
        else     stage_q <= stage_d;
    end

    assign ex_valid      = stage_q.valid;
    assign ex_pc_plus4   = stage_q.pc_plus4;
    assign ex_rd_data1   = stage_q.rd_data1;
    assign ex_rd_data2   = stage_q.rd_data2;
    assign ex_imm_ext    = stage_q.imm_ext;
    assign ex_rs         = stage_q.rs;
    assign ex_rt         = stage_q.rt;
    assign ex_rd         = stage_q.rd;
    assign ex_reg_write  = stage_q.reg_write;
    assign ex_mem_to_reg = stage_q.mem_to_reg;
    assign ex_mem_read   = stage_q.mem_read;
    assign ex_mem_write  = stage_q.mem_write;
    assign ex_branch     = stage_q.branch;
    assign ex_alu_src    = stage_q.alu_src;
    assign ex_reg_dst    = stage_q.reg_dst;
    assign ex_alu_op     = stage_q.alu_op;

    assign load_use = stage_q.valid & stage_q.mem_read & (stage_q.rt != '0) & id_valid &
                      ((stage_q.rt == id_rs) | (stage_q.rt == id_rt));

`ifdef ID_EX_STALL_CNT_EN
    logic [15:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = (stall & ~flush & (cnt_q != 16'hFFFF)) ? cnt_q + 16'd1 : cnt_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign stall_cnt = cnt_q;
`else
    assign stall_cnt = 16'h0000;
`endif
endmodule
